// File: rtl/myproject_mul_22s_15ns_arbiter.sv
// Round-robin arbiter sharing one signed A x unsigned B multiplier among NUM_REQ lanes.
// The registered product is returned together with the index of the lane that issued it.
// Optional statistics counters (op_count, stall_count) are enabled by defining MUL_ARB_STATS_EN.
module myproject_mul_22s_15ns_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned A_WIDTH  = 22,
  parameter int unsigned B_WIDTH  = 15,
  parameter int unsigned P_WIDTH  = A_WIDTH + B_WIDTH,
  parameter int unsigned ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic signed [P_WIDTH-1:0]    rsp_p,
  output logic [ID_WIDTH-1:0]          rsp_id,
`ifdef MUL_ARB_STATS_EN
  output logic [31:0]                  op_count,
  output logic [31:0]                  stall_count,
`endif
  output logic                         busy
);

  logic                        rsp_valid_q, rsp_valid_d;
  logic signed [P_WIDTH-1:0]   rsp_p_q, rsp_p_d;
  logic [ID_WIDTH-1:0]         rsp_id_q, rsp_id_d;
  logic [ID_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]          grant;
  logic [ID_WIDTH-1:0]         grant_idx;
  logic                        grant_any;
  logic                        can_accept;
  logic                        accept;

  logic signed [A_WIDTH-1:0]   a_arr [NUM_REQ];
  logic [B_WIDTH-1:0]          b_arr [NUM_REQ];
  logic signed [A_WIDTH-1:0]   a_sel;
  logic [B_WIDTH-1:0]          b_sel;
  logic signed [P_WIDTH-1:0]   a_ext;
  logic signed [P_WIDTH-1:0]   b_ext;
  logic signed [P_WIDTH-1:0]   prod;

  // Unpack the flat operand buses into per-lane arrays.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*A_WIDTH +: A_WIDTH];
    assign b_arr[g] = req_b[g*B_WIDTH +: B_WIDTH];
  end

  // Round-robin search starting at the lane after the last grant.
  always_comb begin
    int unsigned         sum;
    logic [ID_WIDTH-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      sum = 32'(rr_ptr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_WIDTH'(sum);
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign accept     = grant_any && can_accept;
  assign req_ready  = grant & {NUM_REQ{can_accept}};

  // B is unsigned: zero-extend before the signed multiply so the product keeps full precision.
  assign a_sel = a_arr[grant_idx];
  assign b_sel = b_arr[grant_idx];
  assign a_ext = P_WIDTH'(a_sel);
  assign b_ext = $signed(P_WIDTH'({1'b0, b_sel}));
  assign prod  = a_ext * b_ext;

  // Next-state for the result register and round-robin pointer.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_p_d     = prod;
      rsp_id_d    = grant_idx;
      rr_ptr_d    = grant_idx;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; pointer resets to the last lane so lane 0 wins first.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = rsp_valid_q || (|req_valid);

`ifdef MUL_ARB_STATS_EN
  logic [31:0] op_count_q;
  logic [31:0] stall_count_q;
  logic        stall;

  assign stall = rsp_valid_q && !rsp_ready && (|req_valid);

  // Wrapping accept and stall counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (accept) op_count_q    <= op_count_q + 32'd1;
      if (stall)  stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign op_count    = op_count_q;
  assign stall_count = stall_count_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_myproject_mul_22s_15ns_arbiter.sv
// Directed self-checking bench for myproject_mul_22s_15ns_arbiter.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_myproject_mul_22s_15ns_arbiter;

  localparam int NR = 4;
  localparam int AW = 22;
  localparam int BW = 15;
  localparam int PW = 37;
  localparam int IW = 2;

  logic                   ap_clk;
  logic                   ap_rst_n;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR*AW-1:0]       req_a;
  logic [NR*BW-1:0]       req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic signed [PW-1:0]   rsp_p;
  logic [IW-1:0]          rsp_id;
  logic                   busy;
`ifdef MUL_ARB_STATS_EN
  logic [31:0]            op_count;
  logic [31:0]            stall_count;
`endif

  int checks = 0;
  int errors = 0;

  myproject_mul_22s_15ns_arbiter dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_p       (rsp_p),
    .rsp_id      (rsp_id),
`ifdef MUL_ARB_STATS_EN
    .op_count    (op_count),
    .stall_count (stall_count),
`endif
    .busy        (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic set_lane(input int lane, input logic signed [AW-1:0] a, input logic [BW-1:0] b);
    req_a[lane*AW +: AW] = a;
    req_b[lane*BW +: BW] = b;
  endtask

  task automatic test_reset();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rsp_valid); end
    checks++;
    if (rsp_p !== 37'sd0) begin errors++; $display("FAIL reset_p got %0d exp 0", rsp_p); end
    checks++;
    if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  task automatic test_single();
    set_lane(0, -22'sd2097152, 15'd32767);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy); end
    @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", rsp_valid); end
    checks++;
    if (rsp_p !== -37'sd68717379584) begin
      errors++; $display("FAIL single_p got %0d exp -68717379584", rsp_p);
    end
    checks++;
    if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
  endtask

  task automatic test_extremes();
    set_lane(2, 22'sd2097151, 15'd32767);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL ext2_ready got %b exp 0100", req_ready); end
    @(negedge ap_clk);
    checks++;
    if (rsp_p !== 37'sd68717346817 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL ext2_p got %0d/%0d exp 68717346817/2", rsp_p, rsp_id);
    end
    set_lane(3, -22'sd1, 15'd0);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL ext3_ready got %b exp 1000", req_ready); end
    @(negedge ap_clk);
    checks++;
    if (rsp_p !== 37'sd0 || rsp_id !== 2'd3 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL ext3_p got %0d/%0d/%0b exp 0/3/1", rsp_p, rsp_id, rsp_valid);
    end
    // Drain without a new request: valid drops, data holds.
    req_valid = 4'b0000;
    @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL drain got v%0b id%0d busy%0b exp v0 id3 busy0", rsp_valid, rsp_id, busy);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NR; i++) set_lane(i, AW'(i + 1), 15'd3);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << (k % 4)));
      end
      @(negedge ap_clk);
      checks++;
      if (rsp_id !== 2'(k % 4) || rsp_p !== 37'(3 * (k % 4 + 1)) || rsp_valid !== 1'b1) begin
        errors++; $display("FAIL rr_rsp[%0d] got id%0d p%0d exp id%0d p%0d", k, rsp_id, rsp_p,
                           k % 4, 3 * (k % 4 + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    // Last grant was lane 0 with product 3.
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 37'sd3) begin
        errors++; $display("FAIL bp_hold[%0d] got rdy%b v%0b id%0d p%0d exp 0000/1/0/3", k,
                           req_ready, rsp_valid, rsp_id, rsp_p);
      end
      @(negedge ap_clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume got %b exp 0010", req_ready); end
    @(negedge ap_clk);
    checks++;
    if (rsp_id !== 2'd1 || rsp_p !== 37'sd6) begin
      errors++; $display("FAIL bp_rsp1 got id%0d p%0d exp id1 p6", rsp_id, rsp_p);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next got %b exp 0100", req_ready); end
    @(negedge ap_clk);
    checks++;
    if (rsp_id !== 2'd2 || rsp_p !== 37'sd9) begin
      errors++; $display("FAIL bp_rsp2 got id%0d p%0d exp id2 p9", rsp_id, rsp_p);
    end
  endtask

  task automatic test_async_reset();
    // rsp_valid is 1 here; assert reset mid-cycle.
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_p !== 37'sd0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL async_rst got v%0b p%0d id%0d exp 0/0/0", rsp_valid, rsp_p, rsp_id);
    end
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first got %b exp 0001", req_ready); end
    @(negedge ap_clk);
    checks++;
    if (rsp_id !== 2'd0 || rsp_p !== 37'sd3 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rst_rsp got id%0d p%0d exp id0 p3", rsp_id, rsp_p);
    end
    req_valid = 4'b0000;
    @(negedge ap_clk);
  endtask

`ifdef MUL_ARB_STATS_EN
  task automatic test_stats();
    ap_rst_n  = 1'b0;
    req_valid = 4'b0000;
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    repeat (10) @(negedge ap_clk);
    rsp_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    req_valid = 4'b0000;
    @(negedge ap_clk);
    checks++;
    if (op_count !== 32'd10) begin errors++; $display("FAIL op_count got %0d exp 10", op_count); end
    checks++;
    if (stall_count !== 32'd3) begin errors++; $display("FAIL stall_count got %0d exp 3", stall_count); end
    rsp_ready = 1'b1;
    @(negedge ap_clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_async_reset();
`ifdef MUL_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
